// File: rtl/dac_player_if.sv
// dac_player_if: table-load, playback-control and replayed-signal bundle for dac_player
interface dac_player_if #(
  parameter int sig_bits = 1,
  parameter int addr_bits = 4,
  parameter int time_bits = 32
);
  logic [time_bits-1:0] time_curr, wr_time, loop_period;
  logic wr_en, loop, start, abort, update, busy, done;
  logic [addr_bits-1:0] wr_addr, event_idx;
  logic signed [sig_bits-1:0] wr_sig, sig;
  logic [addr_bits:0] num_events;
  modport master (
    output time_curr, wr_en, wr_addr, wr_time, wr_sig, num_events, loop_period, loop, start, abort,
    input sig, update, event_idx, busy, done
  );
  modport slave (
    input time_curr, wr_en, wr_addr, wr_time, wr_sig, num_events, loop_period, loop, start, abort,
    output sig, update, event_idx, busy, done
  );
endinterface

// File: rtl/dac_player.sv
// dac_player: replays a programmed (relative time, value) event table onto a signed signal
module dac_player #(
  parameter string name = "dac",
  parameter int sig_bits = 1,
  parameter int sig_point = 1,
  parameter int depth = 16,
  parameter int time_bits = 32,
  parameter logic signed [sig_bits-1:0] init_sig = '0
) (
  input logic clk,
  input logic rst,
  dac_player_if.slave bus
);
  localparam int addr_bits = $clog2(depth);
  if (depth < 2 || (depth & (depth - 1)) != 0 || sig_point < 0) begin : g_bad
    $error("%s: depth must be a power of 2 >= 2", name);
  end
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [time_bits+sig_bits-1:0] mem [depth];
  logic [time_bits+sig_bits-1:0] ev;
  logic [time_bits-1:0] base, period, ev_time, lag;
  logic signed [sig_bits-1:0] ev_sig, sig;
  logic [addr_bits-1:0] ptr, event_idx;
  logic [addr_bits:0] num;
  logic loop_q, update, accept, fire, last;
  assign {ev_time, ev_sig} = ev;
  // base can sit ahead of time_curr after a loop advance, so judge the signed distance to the target
  assign lag = bus.time_curr - base - ev_time;
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign fire = state == WAIT && !lag[time_bits-1];
  assign last = {1'b0, ptr} == num - (addr_bits + 1)'(1);
  always_comb begin
    state_n = state;
    if (bus.abort) state_n = IDLE;
    else if (accept) state_n = bus.num_events == '0 ? DONE : FETCH;
    else if (state == FETCH) state_n = WAIT;
    else if (fire) state_n = last && !loop_q ? DONE : FETCH;
  end
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= {bus.wr_time, bus.wr_sig};
    if (state == FETCH) ev <= mem[ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sig <= init_sig;
      update <= 1'b0;
      event_idx <= '0;
      ptr <= '0;
      base <= '0;
      period <= '0;
      num <= '0;
      loop_q <= 1'b0;
    end else begin
      state <= state_n;
      update <= 1'b0;
      if (!bus.abort) begin
        if (accept) begin
          num <= bus.num_events;
          loop_q <= bus.loop;
          period <= bus.loop_period;
          base <= bus.time_curr;
          ptr <= '0;
        end else if (fire) begin
          sig <= ev_sig;
          update <= 1'b1;
          event_idx <= ptr;
          if (!last) ptr <= ptr + addr_bits'(1);
          else if (loop_q) begin
            ptr <= '0;
            base <= base + period;
          end
        end
      end
    end
  end
  assign bus.sig = sig;
  assign bus.update = update;
  assign bus.event_idx = event_idx;
  assign bus.busy = state == FETCH || state == WAIT;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_dac_player.sv
// tb_dac_player: vector table, hand-written corner sequences and randomized runs against a schedule model
module tb_dac_player;
  localparam int W = 16, SB = 4, AB = 3;
  localparam logic signed [SB-1:0] INIT = 4'sd3;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dac_player_if #(.sig_bits(SB), .addr_bits(AB), .time_bits(W)) bus ();
  dac_player #(.name("dac"), .sig_bits(SB), .sig_point(2), .depth(8), .time_bits(W), .init_sig(INIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {logic [W-1:0] t; int s; int idx;} ev_t;
  typedef struct {
    int tt[3]; int ts[3]; int num; bit lp; int per; int st; int ncyc;
    int n; int et[4]; int es[4]; bit dn;
  } vec_t;
  ev_t obs[$], exp_q[$];
  logic [W-1:0] tbl_t [8];
  int tbl_s [8];
  int cmp_n = 0, err_n = 0;
  vec_t vecs [5];
  always @(negedge clk)
    if (bus.update === 1'b1) obs.push_back('{bus.time_curr - W'(1), int'(bus.sig), int'(bus.event_idx)});
  task automatic chk(string nm, int act, int expv);
    cmp_n++;
    if (act !== expv) begin
      err_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1 bus.time_curr = bus.time_curr + W'(1);
  endtask
  task automatic wr(int a, int t, int s);
    bus.wr_en = 1'b1; bus.wr_addr = AB'(a); bus.wr_time = W'(t); bus.wr_sig = SB'(s);
    step();
    bus.wr_en = 1'b0;
    tbl_t[a] = W'(t); tbl_s[a] = s;
  endtask
  task automatic go(int st, int num, bit lp, int per);
    bus.num_events = (AB + 1)'(num); bus.loop = lp; bus.loop_period = W'(per);
    bus.time_curr = W'(st); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic idle();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    obs.delete();
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  // event k fires at the first cycle, no earlier than 2 after the previous one, where time reaches base+t_k
  task automatic model(int st, int num, bit lp, int per, int limit);
    logic [W-1:0] base, rt, ft;
    logic signed [W-1:0] d;
    int k = 0;
    exp_q.delete();
    base = W'(st);
    rt = W'(st + 2);
    while (exp_q.size() < limit) begin
      d = $signed(base + tbl_t[k] - rt);
      ft = d > 0 ? rt + d : rt;
      exp_q.push_back('{ft, tbl_s[k], k});
      rt = ft + W'(2);
      if (k == num - 1) begin
        if (!lp) break;
        base = base + W'(per);
        k = 0;
      end else k++;
    end
  endtask
  task automatic cmp_sched(string nm, bit exact);
    int m = obs.size() < exp_q.size() ? obs.size() : exp_q.size();
    chk({nm, " count"}, exact ? obs.size() : m, exp_q.size());
    for (int i = 0; i < m; i++) begin
      chk({nm, " time"}, int'(obs[i].t), int'(exp_q[i].t));
      chk({nm, " sig"}, obs[i].s, exp_q[i].s);
      chk({nm, " idx"}, obs[i].idx, exp_q[i].idx);
    end
  endtask
  task automatic load3(int t0, int s0, int t1, int s1, int t2, int s2);
    wr(0, t0, s0); wr(1, t1, s1); wr(2, t2, s2);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{'{10, 20, 20}, '{1, -1, 1}, 3, 1'b0, 0, 100, 30, 3, '{110, 120, 122, 0}, '{1, -1, 1, 0}, 1'b1};
    vecs[1] = '{'{8, 0, 0}, '{-3, 0, 0}, 1, 1'b0, 0, 65531, 20, 1, '{3, 0, 0, 0}, '{-3, 0, 0, 0}, 1'b1};
    vecs[2] = '{'{0, 0, 0}, '{1, 2, -4}, 3, 1'b0, 0, 50, 20, 3, '{52, 54, 56, 0}, '{1, 2, -4, 0}, 1'b1};
    vecs[3] = '{'{10, 20, 20}, '{1, -1, 1}, 3, 1'b1, 30, 100, 45, 4, '{110, 120, 122, 140}, '{1, -1, 1, 1}, 1'b0};
    vecs[4] = '{'{5, 5, 30}, '{7, -8, 0}, 2, 1'b0, 0, 1000, 30, 2, '{1005, 1007, 0, 0}, '{7, -8, 0, 0}, 1'b1};
    {bus.time_curr, bus.wr_en, bus.wr_addr, bus.wr_time, bus.wr_sig} = '0;
    {bus.num_events, bus.loop_period, bus.loop, bus.start, bus.abort} = '0;
    run(2);
    chk("reset sig", int'(bus.sig), int'(INIT));
    chk("reset update", int'(bus.update), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset idx", int'(bus.event_idx), 0);
    rst = 1'b0;
    foreach (vecs[v]) begin
      idle();
      load3(vecs[v].tt[0], vecs[v].ts[0], vecs[v].tt[1], vecs[v].ts[1], vecs[v].tt[2], vecs[v].ts[2]);
      obs.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back('{W'(vecs[v].et[i]), vecs[v].es[i], i % vecs[v].num});
      go(vecs[v].st, vecs[v].num, vecs[v].lp, vecs[v].per);
      run(vecs[v].ncyc);
      cmp_sched($sformatf("vec%0d", v), 1'b1);
      chk($sformatf("vec%0d done", v), int'(bus.done), int'(vecs[v].dn));
    end
    idle();
    go(200, 0, 1'b0, 0);
    chk("num0 done", int'(bus.done), 1);
    chk("num0 busy", int'(bus.busy), 0);
    run(5);
    chk("num0 updates", obs.size(), 0);
    idle();
    load3(10, 1, 20, -1, 20, 1);
    obs.delete();
    go(100, 3, 1'b0, 0);
    run(4);
    chk("busy mid", int'(bus.busy), 1);
    bus.num_events = '0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start ignored busy", int'(bus.busy), 1);
    run(25);
    model(100, 3, 1'b0, 0, 3);
    cmp_sched("start busy", 1'b1);
    idle();
    go(100, 3, 1'b1, 30);
    run(50);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    run(10);
    model(100, 3, 1'b1, 30, 5);
    cmp_sched("abort loop", 1'b1);
    chk("abort sig", int'(bus.sig), -1);
    chk("abort idx", int'(bus.event_idx), 1);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    idle();
    go(300, 3, 1'b0, 0);
    run(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst wait sig", int'(bus.sig), int'(INIT));
    chk("rst wait busy", int'(bus.busy), 0);
    chk("rst wait done", int'(bus.done), 0);
    chk("rst wait idx", int'(bus.event_idx), 0);
    run(10);
    chk("rst wait no update", obs.size(), 0);
    go(400, 3, 1'b0, 0);
    run(30);
    model(400, 3, 1'b0, 0, 3);
    cmp_sched("table kept", 1'b1);
    idle();
    go(500, 3, 1'b0, 0);
    run(4);
    wr(2, 25, 7);
    run(25);
    model(500, 3, 1'b0, 0, 3);
    cmp_sched("mid write", 1'b1);
    chk("mid write last sig", int'(bus.sig), 7);
    for (int r = 0; r < 20; r++) begin
      int num = int'($urandom_range(8, 1));
      bit lp = 1'($urandom_range(1, 0));
      int per = int'($urandom_range(40, 0));
      int st = int'($urandom_range(65535, 0));
      idle();
      for (int a = 0; a < num; a++) wr(a, int'($urandom_range(20, 0)), int'($urandom_range(15, 0)) - 8);
      obs.delete();
      model(st, num, lp, per, lp ? 10 : num);
      go(st, num, lp, per);
      for (int i = 0; i < 1500 && obs.size() < exp_q.size(); i++) step();
      run(2);
      cmp_sched($sformatf("rand%0d", r), !lp);
      if (!lp) chk($sformatf("rand%0d done", r), int'(bus.done), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
